// File: rtl/simple_alu_pkg.sv
// Shared encodings for the execute-stage ALU: opcodes, shifter modes, flag bit positions.
package simple_alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_MUL  = 4'b0010,
        OP_OR   = 4'b0011,
        OP_AND  = 4'b0100,
        OP_XOR  = 4'b0101,
        OP_MOVI = 4'b0110,
        OP_MOV  = 4'b0111,
        OP_LDR  = 4'b1101,
        OP_STR  = 4'b1110
    } opcode_e;

    typedef enum logic [2:0] {
        SH_NONE = 3'b000,
        SH_LSR  = 3'b001,
        SH_LSL  = 3'b010,
        SH_ROR  = 3'b011,
        SH_ASR  = 3'b100
    } shift_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Only the data-processing group (opcode MSB clear) may write the flags.
    function automatic logic flag_write_en(input logic s, input logic [3:0] op);
        return s && !op[3];
    endfunction

endpackage

// File: rtl/simple_alu_shifter.sv
// Barrel shifter applied to operand B, with the last bit shifted out as carry.
module alu_shifter
    import simple_alu_pkg::*;
(
    input  logic [31:0] In2,
    input  logic [2:0]  SR_Cont,
    input  logic [4:0]  SR_Bit,
    output logic [31:0] B,
    output logic        Cout
);

    logic signed [31:0] in2_s;
    logic        [63:0] rot_w;
    logic        [4:0]  idx_r;
    logic        [4:0]  idx_l;

    assign in2_s = In2;
    // Rotation is a right shift of the operand concatenated with itself.
    assign rot_w = {In2, In2} >> SR_Bit;
    // Right-going shifts lose bit n-1 last; a left shift by n loses bit 32-n last.
    assign idx_r = SR_Bit - 5'd1;
    assign idx_l = 5'd0 - SR_Bit;

    // Select the shifted operand and its carry; amount 0 is always a pass-through.
    always_comb begin
        B    = In2;
        Cout = 1'b0;
        if (SR_Bit != 5'd0) begin
            case (SR_Cont)
                SH_LSR: begin
                    B    = In2 >> SR_Bit;
                    Cout = In2[idx_r];
                end
                SH_LSL: begin
                    B    = In2 << SR_Bit;
                    Cout = In2[idx_l];
                end
                SH_ROR: begin
                    B    = rot_w[31:0];
                    Cout = In2[idx_r];
                end
                SH_ASR: begin
                    B    = $unsigned(in2_s >>> SR_Bit);
                    Cout = In2[idx_r];
                end
                default: begin
                    B    = In2;
                    Cout = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/simple_alu.sv
// Execute-stage ALU: combinational result mux over a shifted operand, plus a registered NZCV register.
module simple_alu
    import simple_alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] In1,
    input  logic [31:0] In2,
    input  logic [3:0]  Opcode,
    input  logic [4:0]  SR_Bit,
    input  logic [2:0]  SR_Cont,
    input  logic        S,
    input  logic [15:0] Immediate,
    output logic [31:0] Out,
    output logic [3:0]  Flags
);

    logic [31:0] b_w;
    logic        sh_c_w;
    logic [32:0] sum_w;
    logic [32:0] diff_w;
    logic [31:0] mul_w;
    logic        add_v_w;
    logic        sub_v_w;
    logic [3:0]  flags_d;
    logic [3:0]  flags_q;

    alu_shifter u_shifter (
        .In2     (In2),
        .SR_Cont (SR_Cont),
        .SR_Bit  (SR_Bit),
        .B       (b_w),
        .Cout    (sh_c_w)
    );

    // 33-bit add/subtract keeps the carry/borrow in bit 32.
    assign sum_w   = {1'b0, In1} + {1'b0, b_w};
    assign diff_w  = {1'b0, In1} - {1'b0, b_w};
    assign mul_w   = In1 * b_w;
    // Signed overflow: result sign disagrees with what the operand signs allow.
    assign add_v_w = (In1[31] == b_w[31]) && (sum_w[31]  != In1[31]);
    assign sub_v_w = (In1[31] != b_w[31]) && (diff_w[31] != In1[31]);

    // Result mux; undefined opcodes drive zero.
    always_comb begin
        Out = 32'd0;
        case (Opcode)
            OP_ADD:  Out = sum_w[31:0];
            OP_SUB:  Out = diff_w[31:0];
            OP_MUL:  Out = mul_w;
            OP_OR:   Out = In1 | b_w;
            OP_AND:  Out = In1 & b_w;
            OP_XOR:  Out = In1 ^ b_w;
            OP_MOVI: Out = {16'd0, Immediate};
            OP_MOV:  Out = In1;
            OP_LDR:  Out = In1;
            OP_STR:  Out = In1;
            default: Out = 32'd0;
        endcase
    end

    // Next flag value: N/Z from the result; C/V depend on the operation class.
    always_comb begin
        flags_d = flags_q;
        if (flag_write_en(S, Opcode)) begin
            flags_d[FLAG_N] = Out[31];
            flags_d[FLAG_Z] = (Out == 32'd0);
            case (Opcode)
                OP_ADD: begin
                    flags_d[FLAG_C] = sum_w[32];
                    flags_d[FLAG_V] = add_v_w;
                end
                OP_SUB: begin
                    flags_d[FLAG_C] = ~diff_w[32];
                    flags_d[FLAG_V] = sub_v_w;
                end
                OP_MUL: begin
                    flags_d[FLAG_C] = flags_q[FLAG_C];
                    flags_d[FLAG_V] = flags_q[FLAG_V];
                end
                default: begin
                    flags_d[FLAG_C] = sh_c_w;
                    flags_d[FLAG_V] = flags_q[FLAG_V];
                end
            endcase
        end
    end

    // Flag register; reset clears it immediately regardless of the clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= 4'b0000;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign Flags = flags_q;

endmodule

// File: tb/tb_simple_alu.sv
module tb_simple_alu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] In1 = 32'd0;
    logic [31:0] In2 = 32'd0;
    logic [3:0]  Opcode = 4'd0;
    logic [4:0]  SR_Bit = 5'd0;
    logic [2:0]  SR_Cont = 3'd0;
    logic        S = 1'b0;
    logic [15:0] Immediate = 16'd0;
    logic [31:0] Out;
    logic [3:0]  Flags;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [31:0] out;
        logic [3:0]  flags;
    } exp_t;

    exp_t sb_q[$];
    bit   drv_vld  = 1'b0;
    bit   drv_done = 1'b0;
    logic [3:0] m_flags;

    simple_alu dut (
        .clk       (clk),
        .rst       (rst),
        .In1       (In1),
        .In2       (In2),
        .Opcode    (Opcode),
        .SR_Bit    (SR_Bit),
        .SR_Cont   (SR_Cont),
        .S         (S),
        .Immediate (Immediate),
        .Out       (Out),
        .Flags     (Flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model written from the arithmetic definitions with 64-bit integers.
    task automatic ref_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [2:0] sc, input logic [4:0] sb, input logic s,
                             input logic [15:0] imm, input logic [3:0] fin,
                             output logic [31:0] out, output logic [3:0] fout);
        longint unsigned av, bv, t, bs, mask;
        longint sx, sr;
        logic [31:0] bs32;
        int n;
        logic c_sh, c, v;
        mask = 64'h0000_0000_FFFF_FFFF;
        av = a;
        bv = b;
        n = int'(sb);
        bs = bv;
        c_sh = 1'b0;
        if (n != 0) begin
            if (sc == 3'd1) begin
                bs = bv >> n;
                c_sh = ((bv >> (n - 1)) & 64'd1) != 0;
            end else if (sc == 3'd2) begin
                t = bv << n;
                bs = t & mask;
                c_sh = t[32];
            end else if (sc == 3'd3) begin
                t = (bv >> n) | (bv << (32 - n));
                bs = t & mask;
                c_sh = ((bv >> (n - 1)) & 64'd1) != 0;
            end else if (sc == 3'd4) begin
                sx = longint'($signed(b));
                bs = longint'(sx >>> n) & mask;
                c_sh = ((bv >> (n - 1)) & 64'd1) != 0;
            end
        end
        bs32 = bs[31:0];
        out = 32'd0;
        c = fin[1];
        v = fin[0];
        case (op)
            4'd0: begin
                t = av + bs;
                out = t[31:0];
                c = t > mask;
                sr = longint'($signed(a)) + longint'($signed(bs32));
                v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'd1: begin
                out = a - bs32;
                c = av >= bs;
                sr = longint'($signed(a)) - longint'($signed(bs32));
                v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'd2: begin
                t = av * bs;
                out = t[31:0];
            end
            4'd3: begin out = a | bs32; c = c_sh; end
            4'd4: begin out = a & bs32; c = c_sh; end
            4'd5: begin out = a ^ bs32; c = c_sh; end
            4'd6: begin out = {16'd0, imm}; c = c_sh; end
            4'd7: begin out = a; c = c_sh; end
            4'd13, 4'd14: out = a;
            default: out = 32'd0;
        endcase
        if (s && op <= 4'd7) fout = {out[31], out == 32'd0, c, v};
        else fout = fin;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] sc, input logic [4:0] sb, input logic s,
                         input logic [15:0] imm);
        @(posedge clk);
        #1;
        Opcode = op; In1 = a; In2 = b; SR_Cont = sc; SR_Bit = sb; S = s; Immediate = imm;
    endtask

    // Directed step: Out for these inputs, Flags as left by the previous step's edge.
    task automatic dir(input string nm, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [2:0] sc, input logic [4:0] sb,
                       input logic s, input logic [15:0] imm,
                       input logic [31:0] exp_out, input logic [3:0] exp_flags);
        drive(op, a, b, sc, sb, s, imm);
        @(negedge clk);
        chk({nm, "_out"}, Out, exp_out);
        chk({nm, "_flags"}, {28'd0, Flags}, {28'd0, exp_flags});
    endtask

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [3:0]  r_op;
        logic [31:0] r_a, r_b, e_out;
        logic [2:0]  r_sc;
        logic [4:0]  r_sb;
        logic        r_s;
        logic [15:0] r_imm;
        logic [3:0]  f_next;
        exp_t        e;

        // Reset state, with Out already live during reset.
        In1 = 32'd7; In2 = 32'd5; Opcode = 4'd0; S = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("reset_flags", {28'd0, Flags}, 32'd0);
        chk("reset_out_live", Out, 32'd12);
        S = 1'b0;
        rst = 1'b0;

        // Arithmetic, logic, shifter and move cases with constant expectations.
        dir("add",      4'h0, 32'd15, 32'd20, 3'd0, 5'd0, 1'b0, 16'd0, 32'd35, 4'b0000);
        dir("sub",      4'h1, 32'd30, 32'd10, 3'd0, 5'd0, 1'b0, 16'd0, 32'd20, 4'b0000);
        dir("mul",      4'h2, 32'd5,  32'd5,  3'd0, 5'd0, 1'b0, 16'd0, 32'd25, 4'b0000);
        dir("sub_neg",  4'h1, 32'd0,  32'd1,  3'd0, 5'd0, 1'b1, 16'd0, 32'hFFFF_FFFF, 4'b0000);
        dir("or",       4'h3, 32'h0A0, 32'h005, 3'd0, 5'd0, 1'b0, 16'd0, 32'h0A5, 4'b1000);
        dir("and",      4'h4, 32'h0F0, 32'h00F, 3'd0, 5'd0, 1'b1, 16'd0, 32'h000, 4'b1000);
        dir("xor",      4'h5, 32'h0FF, 32'h0F0, 3'd0, 5'd0, 1'b0, 16'd0, 32'h00F, 4'b0100);
        dir("lsr",      4'h0, 32'd30, 32'd10, 3'd1, 5'd4, 1'b0, 16'd0, 32'd30, 4'b0100);
        dir("lsl",      4'h0, 32'd30, 32'd10, 3'd2, 5'd4, 1'b0, 16'd0, 32'd190, 4'b0100);
        dir("ror",      4'h0, 32'd30, 32'd10, 3'd3, 5'd4, 1'b0, 16'd0, 32'hA000_001E, 4'b0100);
        dir("asr",      4'h0, 32'd0, 32'h8000_0000, 3'd4, 5'd4, 1'b0, 16'd0, 32'hF800_0000, 4'b0100);
        dir("movi",     4'h6, 32'd30, 32'd0,  3'd0, 5'd0, 1'b0, 16'd60, 32'd60, 4'b0100);
        dir("mov",      4'h7, 32'd30, 32'd0,  3'd0, 5'd0, 1'b0, 16'd0, 32'd30, 4'b0100);
        dir("add_ovf",  4'h0, 32'h7FFF_FFFF, 32'd1, 3'd0, 5'd0, 1'b1, 16'd0, 32'h8000_0000, 4'b0100);
        dir("ldr",      4'hD, 32'd30, 32'd9,  3'd0, 5'd0, 1'b1, 16'd0, 32'd30, 4'b1001);
        dir("str",      4'hE, 32'd30, 32'd9,  3'd0, 5'd0, 1'b1, 16'd0, 32'd30, 4'b1001);
        dir("undef",    4'hF, 32'd30, 32'd9,  3'd0, 5'd0, 1'b1, 16'd0, 32'd0,  4'b1001);
        dir("add_carry",4'h0, 32'hFFFF_FFFF, 32'd1, 3'd0, 5'd0, 1'b1, 16'd0, 32'd0, 4'b1001);
        dir("add_s0",   4'h0, 32'h7FFF_FFFF, 32'd1, 3'd0, 5'd0, 1'b0, 16'd0, 32'h8000_0000, 4'b0110);
        dir("mov_s0",   4'h7, 32'd5,  32'd0,  3'd0, 5'd0, 1'b0, 16'd0, 32'd5,  4'b0110);

        // Reset asserted between edges clears Flags at once while Out keeps tracking.
        drive(4'h0, 32'd15, 32'd20, 3'd0, 5'd0, 1'b0, 16'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_flags", {28'd0, Flags}, 32'd0);
        chk("midrst_out", Out, 32'd35);
        In1 = 32'd16;
        #1;
        chk("midrst_out_track", Out, 32'd36);
        @(negedge clk);
        rst = 1'b0;
        dir("post_rst_add", 4'h0, 32'h7FFF_FFFF, 32'd1, 3'd0, 5'd0, 1'b1, 16'd0, 32'h8000_0000, 4'b0000);
        dir("post_rst_mov", 4'h7, 32'd1, 32'd0, 3'd0, 5'd0, 1'b0, 16'd0, 32'd1, 4'b1001);

        // Randomized scoreboard phase from a clean flag state.
        @(negedge clk);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        m_flags = 4'b0000;
        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    r_op  = 4'($urandom_range(0, 15));
                    r_a   = pick32();
                    r_b   = pick32();
                    r_sc  = 3'($urandom_range(0, 7));
                    r_sb  = 5'($urandom_range(0, 31));
                    r_s   = 1'($urandom_range(0, 1));
                    r_imm = 16'($urandom);
                    drive(r_op, r_a, r_b, r_sc, r_sb, r_s, r_imm);
                    ref_model(r_op, r_a, r_b, r_sc, r_sb, r_s, r_imm, m_flags, e_out, f_next);
                    sb_q.push_back({e_out, m_flags});
                    m_flags = f_next;
                    drv_vld = 1'b1;
                end
                @(posedge clk);
                #1;
                drv_vld = 1'b0;
                drv_done = 1'b1;
            end
            begin
                int budget;
                budget = 0;
                while (!drv_done && budget < 2000) begin
                    @(negedge clk);
                    budget++;
                    if (drv_vld) begin
                        if (sb_q.size() == 0) begin
                            chk("sb_underflow", 32'd1, 32'd0);
                        end else begin
                            e = sb_q.pop_front();
                            chk("rnd_out", Out, e.out);
                            chk("rnd_flags", {28'd0, Flags}, {28'd0, e.flags});
                        end
                    end
                end
                if (budget >= 2000) chk("sb_timeout", 32'(budget), 32'd0);
            end
        join
        chk("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
